wb_cmd_master: RTL and testbench

Wishbone pipelined-mode bus initiator that turns single-word commands from a local valid/ready command port into Wishbone transactions and returns each result on a valid/ready response port. It drives the Wishbone slave interface of the generated register blocks (wb_cyc/stb/adr/sel/we/dat, ack/err/rty/stall) and sits between a sequencer, CPU bridge or test controller and those blocks. It keeps one transaction outstanding at a time and has an optional watchdog timeout.

---
 rtl/wb_cmd_master.sv | 149 ++++++++++++++
 tb/tb_wb_cmd_master.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_cmd_master.sv
// wb_cmd_master: single-outstanding Wishbone pipelined initiator fed by a valid/ready command port
// Ports:
//   clk_i, rst_n_i            - clock, synchronous active-low reset
//   cmd_valid_i/cmd_ready_o   - command handshake; cmd_we_i/adr_i/sel_i/dat_i carry the command
//   rsp_valid_o/rsp_ready_i   - response handshake; rsp_dat_o/err_o/timeout_o carry the result
//   wb_*                      - Wishbone pipelined-mode master (cyc/stb/we/adr/sel/dat, ack/err/rty/stall)
// Build option: define WB_MASTER_TIMEOUT_EN to add a TIMEOUT-cycle watchdog on REQ/WAIT.
module wb_cmd_master #(
    parameter int ADDR_W  = 4,
    parameter int TIMEOUT = 255
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_we_i,
    input  logic [ADDR_W-1:0] cmd_adr_i,
    input  logic [3:0]        cmd_sel_i,
    input  logic [31:0]       cmd_dat_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [31:0]       rsp_dat_o,
    output logic              rsp_err_o,
    output logic              rsp_timeout_o,
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    output logic              wb_we_o,
    output logic [ADDR_W-3:0] wb_adr_o,
    output logic [3:0]        wb_sel_o,
    output logic [31:0]       wb_dat_o,
    input  logic [31:0]       wb_dat_i,
    input  logic              wb_ack_i,
    input  logic              wb_err_i,
    input  logic              wb_rty_i,
    input  logic              wb_stall_i
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, RSP} state_t;

    state_t            state_q, state_d;
    logic              we_q, we_d;
    logic [ADDR_W-3:0] adr_q, adr_d;
    logic [3:0]        sel_q, sel_d;
    logic [31:0]       dat_q, dat_d;
    logic [31:0]       rsp_dat_q, rsp_dat_d;
    logic              rsp_err_q, rsp_err_d;
    logic              active, term, bus_err, expire, done;
    logic              unused_adr;

    assign active  = state_q == REQ || state_q == WAIT;
    assign term    = wb_ack_i | wb_err_i | wb_rty_i;
    assign bus_err = wb_err_i | wb_rty_i;
    // a slave termination and a watchdog expiry both end the bus cycle
    assign done    = active && (term || expire);

    assign unused_adr = ^cmd_adr_i[1:0];

`ifdef WB_MASTER_TIMEOUT_EN
    logic [15:0] cnt_q, cnt_d;
    logic        rsp_to_q, rsp_to_d;

    // expiry fires in the TIMEOUT-th cycle spent in REQ/WAIT
    assign expire = active && ({1'b0, cnt_q} + 17'd1 == 17'(TIMEOUT));

    always_comb begin
        cnt_d    = state_q == IDLE ? 16'd0 : active ? cnt_q + 16'd1 : cnt_q;
        rsp_to_d = done ? !term : rsp_to_q;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt_q    <= 16'd0;
            rsp_to_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            rsp_to_q <= rsp_to_d;
        end
    end

    assign rsp_timeout_o = rsp_to_q;
`else
    logic unused_cfg;

    assign expire        = 1'b0;
    assign rsp_timeout_o = 1'b0;
    assign unused_cfg    = TIMEOUT != 0;
`endif

    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        adr_d     = adr_q;
        sel_d     = sel_q;
        dat_d     = dat_q;
        rsp_dat_d = rsp_dat_q;
        rsp_err_d = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid_i) begin
                    we_d    = cmd_we_i;
                    adr_d   = cmd_adr_i[ADDR_W-1:2];
                    sel_d   = cmd_sel_i;
                    dat_d   = cmd_dat_i;
                    state_d = REQ;
                end
            end
            // termination beats stall; an unstalled strobe moves on to WAIT
            REQ:     state_d = done ? RSP : wb_stall_i ? REQ : WAIT;
            WAIT:    state_d = done ? RSP : WAIT;
            RSP:     state_d = rsp_ready_i ? IDLE : RSP;
            default: state_d = IDLE;
        endcase
        // err > rty > ack: any error flag discards the data
        if (done) begin
            rsp_dat_d = (wb_ack_i && !bus_err && !we_q) ? wb_dat_i : 32'd0;
            rsp_err_d = bus_err || !term;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            we_q      <= 1'b0;
            adr_q     <= '0;
            sel_q     <= 4'd0;
            dat_q     <= 32'd0;
            rsp_dat_q <= 32'd0;
            rsp_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            we_q      <= we_d;
            adr_q     <= adr_d;
            sel_q     <= sel_d;
            dat_q     <= dat_d;
            rsp_dat_q <= rsp_dat_d;
            rsp_err_q <= rsp_err_d;
        end
    end

    assign cmd_ready_o = rst_n_i && state_q == IDLE;
    assign rsp_valid_o = state_q == RSP;
    assign rsp_dat_o   = rsp_dat_q;
    assign rsp_err_o   = rsp_err_q;
    assign wb_cyc_o    = active;
    assign wb_stb_o    = state_q == REQ;
    assign wb_we_o     = we_q;
    assign wb_adr_o    = adr_q;
    assign wb_sel_o    = sel_q;
    assign wb_dat_o    = dat_q;
endmodule

// File: tb/tb_wb_cmd_master.sv
// tb_wb_cmd_master: randomized self-checking bench for wb_cmd_master against a word-memory reference model
module tb_wb_cmd_master;
    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        cmd_valid_i, cmd_ready_o, cmd_we_i;
    logic [3:0]  cmd_adr_i, cmd_sel_i;
    logic [31:0] cmd_dat_i;
    logic        rsp_valid_o, rsp_ready_i, rsp_err_o, rsp_timeout_o;
    logic [31:0] rsp_dat_o;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [1:0]  wb_adr_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_dat_o, wb_dat_i;
    logic        wb_ack_i, wb_err_i, wb_rty_i, wb_stall_i;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] ref_mem [4];
    logic [31:0] slv_mem [4];

    wb_cmd_master #(.ADDR_W(4), .TIMEOUT(16)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
        .cmd_adr_i(cmd_adr_i), .cmd_sel_i(cmd_sel_i), .cmd_dat_i(cmd_dat_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_dat_o(rsp_dat_o),
        .rsp_err_o(rsp_err_o), .rsp_timeout_o(rsp_timeout_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_adr_o(wb_adr_o), .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
        .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i), .wb_stall_i(wb_stall_i)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
        merge = o;
        for (int b = 0; b < 4; b++) if (s[b]) merge[8*b +: 8] = n[8*b +: 8];
    endfunction

    task automatic issue(input logic we, input logic [3:0] adr, input logic [3:0] sel, input logic [31:0] dat);
        int t = 0;
        while (!cmd_ready_o && t < 20) begin
            @(negedge clk_i);
            t++;
        end
        chk("cmd_ready_idle", cmd_ready_o, 1'b1);
        cmd_valid_i = 1'b1;
        cmd_we_i    = we;
        cmd_adr_i   = adr;
        cmd_sel_i   = sel;
        cmd_dat_i   = dat;
        @(negedge clk_i);
        cmd_valid_i = 1'b0;
        cmd_we_i    = 1'($urandom);
        cmd_adr_i   = 4'($urandom);
        cmd_sel_i   = 4'($urandom);
        cmd_dat_i   = $urandom;
    endtask

    // kind: 0 ack, 1 err (maybe with rty/ack), 2 rty (maybe with ack); k stall cycles, w wait cycles, d ready delay
    task automatic run_txn(input logic we, input logic [3:0] adr, input logic [3:0] sel, input logic [31:0] dat,
                           input int k, input int w, input int kind, input int d);
        logic [31:0] exp_dat;
        logic        exp_err;
        int          last;
        last    = k + 1 + w;
        exp_err = kind != 0;
        exp_dat = (kind == 0 && !we) ? ref_mem[adr[3:2]] : 32'd0;
        if (kind == 0 && we) ref_mem[adr[3:2]] = merge(ref_mem[adr[3:2]], dat, sel);
        issue(we, adr, sel, dat);
        for (int c = 1; c <= last; c++) begin
            chk("cyc", wb_cyc_o, 1'b1);
            chk("stb", wb_stb_o, c <= k + 1);
            chk("adr", wb_adr_o, adr[3:2]);
            chk("we", wb_we_o, we);
            chk("sel", wb_sel_o, sel);
            chk("wdat", wb_dat_o, dat);
            chk("busy_ready", cmd_ready_o, 1'b0);
            chk("busy_rsp", rsp_valid_o, 1'b0);
            wb_stall_i = c <= k ? 1'b1 : c > k + 1 ? 1'($urandom) : 1'b0;
            wb_ack_i   = c == last && (kind == 0 || 1'($urandom));
            wb_err_i   = c == last && kind == 1;
            wb_rty_i   = c == last && (kind == 2 || (kind == 1 && 1'($urandom)));
            wb_dat_i   = (c == last && kind == 0 && !wb_we_o) ? slv_mem[wb_adr_o] : $urandom;
            if (c == last && kind == 0 && wb_we_o) slv_mem[wb_adr_o] = merge(slv_mem[wb_adr_o], wb_dat_o, wb_sel_o);
            @(negedge clk_i);
        end
        {wb_ack_i, wb_err_i, wb_rty_i, wb_stall_i} = 4'b0;
        wb_dat_i = $urandom;
        for (int i = 0; i <= d; i++) begin
            chk("rsp_valid", rsp_valid_o, 1'b1);
            chk("rsp_cyc", wb_cyc_o, 1'b0);
            chk("rsp_stb", wb_stb_o, 1'b0);
            chk("rsp_ready_blk", cmd_ready_o, 1'b0);
            chk("rsp_dat", rsp_dat_o, exp_dat);
            chk("rsp_err", rsp_err_o, exp_err);
            chk("rsp_timeout", rsp_timeout_o, 1'b0);
            rsp_ready_i = i == d;
            cmd_valid_i = 1'($urandom);
            @(negedge clk_i);
        end
        cmd_valid_i = 1'b0;
        rsp_ready_i = 1'b0;
        chk("post_valid", rsp_valid_o, 1'b0);
        chk("post_cyc", wb_cyc_o, 1'b0);
        chk("post_ready", cmd_ready_o, 1'b1);
    endtask

    initial begin
        int n;
        rst_n_i = 1'b0;
        {cmd_valid_i, cmd_we_i, rsp_ready_i} = 3'b0;
        cmd_adr_i = 4'd0;
        cmd_sel_i = 4'd0;
        cmd_dat_i = 32'd0;
        {wb_ack_i, wb_err_i, wb_rty_i, wb_stall_i} = 4'b0;
        wb_dat_i = 32'd0;
        for (int i = 0; i < 4; i++) begin
            ref_mem[i] = $urandom;
            slv_mem[i] = ref_mem[i];
        end
        repeat (3) @(negedge clk_i);
        chk("rst_ready", cmd_ready_o, 1'b0);
        chk("rst_cyc", wb_cyc_o, 1'b0);
        chk("rst_stb", wb_stb_o, 1'b0);
        chk("rst_valid", rsp_valid_o, 1'b0);
        chk("rst_rdat", rsp_dat_o, 32'd0);
        chk("rst_err", {rsp_err_o, rsp_timeout_o}, 2'b00);
        rst_n_i = 1'b1;
        @(negedge clk_i);
        chk("idle_ready", cmd_ready_o, 1'b1);

        run_txn(1'b1, 4'h0, 4'hF, 32'h12345678, 0, 2, 0, 0);
        run_txn(1'b0, 4'h0, 4'hF, 32'h0, 0, 0, 0, 0);
        chk("wr_readback", slv_mem[0], 32'h12345678);
        run_txn(1'b1, 4'h4, 4'hF, 32'hCAFEF00D, 0, 0, 0, 0);
        run_txn(1'b0, 4'h4, 4'hF, 32'h0, 3, 0, 0, 1);
        run_txn(1'b1, 4'h8, 4'h3, 32'h11111111, 1, 1, 1, 0);
        run_txn(1'b0, 4'hC, 4'hF, 32'h0, 0, 2, 2, 0);
        run_txn(1'b1, 4'hC, 4'hF, 32'hA5A5A5A5, 0, 0, 0, 0);
        run_txn(1'b0, 4'hC, 4'hF, 32'h0, 1, 0, 0, 5);

        for (int i = 0; i < 40; i++) begin
            int r;
            r = int'($urandom % 10);
            run_txn(1'($urandom), 4'($urandom), 4'($urandom), $urandom,
                    int'($urandom % 4), int'($urandom % 4), r < 6 ? 0 : r < 8 ? 1 : 2, int'($urandom % 3));
        end

        issue(1'b1, 4'h8, 4'hF, 32'hDEADBEEF);
        @(negedge clk_i);
        chk("mid_wait_cyc", wb_cyc_o, 1'b1);
        chk("mid_wait_stb", wb_stb_o, 1'b0);
        rst_n_i = 1'b0;
        @(negedge clk_i);
        chk("mid_rst_cyc", {wb_cyc_o, wb_stb_o, wb_we_o}, 3'b000);
        chk("mid_rst_valid", rsp_valid_o, 1'b0);
        chk("mid_rst_ready", cmd_ready_o, 1'b0);
        chk("mid_rst_bus", {wb_adr_o, wb_sel_o}, 6'd0);
        chk("mid_rst_wdat", wb_dat_o, 32'd0);
        rst_n_i = 1'b1;
        repeat (3) begin
            @(negedge clk_i);
            chk("after_rst_valid", rsp_valid_o, 1'b0);
            chk("after_rst_cyc", wb_cyc_o, 1'b0);
        end
        run_txn(1'b0, 4'h8, 4'hF, 32'h0, 0, 0, 0, 0);

`ifdef WB_MASTER_TIMEOUT_EN
        issue(1'b0, 4'h4, 4'hF, 32'h0);
        n = 0;
        while (wb_cyc_o && n < 100) begin
            wb_stall_i = 1'($urandom);
            wb_dat_i   = $urandom;
            @(negedge clk_i);
            n++;
        end
        wb_stall_i = 1'b0;
        chk("to_cycles", n, 16);
        chk("to_valid", rsp_valid_o, 1'b1);
        chk("to_err", rsp_err_o, 1'b1);
        chk("to_flag", rsp_timeout_o, 1'b1);
        chk("to_dat", rsp_dat_o, 32'd0);
        rsp_ready_i = 1'b1;
        @(negedge clk_i);
        rsp_ready_i = 1'b0;
        chk("to_done", rsp_valid_o, 1'b0);
`else
        issue(1'b0, 4'h4, 4'hF, 32'h0);
        n = 0;
        repeat (1000) begin
            wb_stall_i = 1'($urandom);
            @(negedge clk_i);
            n++;
        end
        wb_stall_i = 1'b0;
        chk("hang_cyc", wb_cyc_o, 1'b1);
        chk("hang_valid", rsp_valid_o, 1'b0);
        chk("hang_to", rsp_timeout_o, 1'b0);
        rst_n_i = 1'b0;
        @(negedge clk_i);
        rst_n_i = 1'b1;
        @(negedge clk_i);
        chk("hang_recover", wb_cyc_o, 1'b0);
`endif
        run_txn(1'b0, 4'h4, 4'hF, 32'h0, 2, 1, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
